// File: rtl/uart_host_if.sv
// Host register interface for a UART core: DATA/CTRL/STATUS/CLKDIV words with a
// ready handshake, TX push / RX pop strobes and a level interrupt.
module uart_host_if #(
  parameter logic [15:0] CLKDIV_RST = 16'd867
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_addr,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_irq,
  output logic [15:0] o_clk_div,
  output logic        o_txen,
  output logic        o_rxen,
  output logic [1:0]  o_length,
  output logic        o_stop2,
  output logic        o_parity,
  output logic        o_odd,
  output logic        o_clear_txbuf,
  output logic        o_clear_rxbuf,
  output logic        o_rst_err,
  output logic [8:0]  o_data_in,
  output logic        o_txwr,
  input  logic [8:0]  i_data_out,
  output logic        o_rxrd,
  input  logic        i_txbuf_empty,
  input  logic        i_txbuf_half,
  input  logic        i_txbuf_full,
  input  logic        i_rxbuf_empty,
  input  logic        i_rxbuf_half,
  input  logic        i_rxbuf_full,
  input  logic        i_overrun_err,
  input  logic        i_parity_err
);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_CLKDIV = 2'd3;

  typedef enum logic [1:0] {IDLE, POP, CAPT, ACK} state_t;

  state_t      state, state_nxt;
  logic [10:0] ctrl;
  logic [15:0] clk_div;
  logic        tx_drop;
  logic        wr_go, rd_direct, pop_go;
  logic        drop_now, drop_clr;
  logic [8:0]  status;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign unused_wdata = ^i_wdata[31:19];

  assign status = {tx_drop, i_parity_err, i_overrun_err,
                   i_rxbuf_full, i_rxbuf_half, i_rxbuf_empty,
                   i_txbuf_full, i_txbuf_half, i_txbuf_empty};

  // Writes win over reads; a DATA read only pops when the RX buffer holds a word.
  always_comb begin
    wr_go     = (state == IDLE) && i_we;
    rd_direct = (state == IDLE) && !i_we && i_re &&
                ((i_addr != A_DATA) || i_rxbuf_empty);
    pop_go    = (state == IDLE) && !i_we && i_re &&
                (i_addr == A_DATA) && !i_rxbuf_empty;
    drop_now  = wr_go && (i_addr == A_DATA) && i_txbuf_full;
    drop_clr  = wr_go && (i_addr == A_STATUS) && i_wdata[8];
  end

  always_comb begin
    rd_mux = 32'h0;
    unique case (i_addr)
      A_DATA:   rd_mux = 32'h8000_0000;
      A_CTRL:   rd_mux = {21'h0, ctrl};
      A_STATUS: rd_mux = {23'h0, status};
      A_CLKDIV: rd_mux = {16'h0, clk_div};
      default:  rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (wr_go || rd_direct) state_nxt = ACK;
        else if (pop_go)        state_nxt = POP;
      end
      POP:     state_nxt = CAPT;
      CAPT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl          <= 11'h0;
      clk_div       <= CLKDIV_RST;
      tx_drop       <= 1'b0;
      o_rdata       <= 32'h0;
      o_irq         <= 1'b0;
      o_txwr        <= 1'b0;
      o_data_in     <= 9'h0;
      o_clear_txbuf <= 1'b0;
      o_clear_rxbuf <= 1'b0;
      o_rst_err     <= 1'b0;
    end else begin
      o_txwr        <= 1'b0;
      o_clear_txbuf <= 1'b0;
      o_clear_rxbuf <= 1'b0;
      o_rst_err     <= 1'b0;
      o_irq <= (ctrl[8] & ~i_rxbuf_empty) | (ctrl[9] & i_txbuf_empty) |
               (ctrl[10] & (i_overrun_err | i_parity_err));
      if (wr_go) begin
        unique case (i_addr)
          A_DATA: begin
            if (!i_txbuf_full) begin
              o_txwr    <= 1'b1;
              o_data_in <= i_wdata[8:0];
            end
          end
          A_CTRL: begin
            ctrl          <= i_wdata[10:0];
            o_clear_txbuf <= i_wdata[16];
            o_clear_rxbuf <= i_wdata[17];
            o_rst_err     <= i_wdata[18];
          end
          A_CLKDIV: clk_div <= i_wdata[15:0];
          default: ;
        endcase
      end
      // A drop in the same cycle as a clear request keeps the sticky flag set.
      if (drop_now)      tx_drop <= 1'b1;
      else if (drop_clr) tx_drop <= 1'b0;
      if (rd_direct)          o_rdata <= rd_mux;
      else if (state == CAPT) o_rdata <= {23'h0, i_data_out};
    end
  end

  assign o_ready   = (state == ACK);
  assign o_rxrd    = (state == POP);
  assign o_clk_div = clk_div;
  assign o_txen    = ctrl[0];
  assign o_rxen    = ctrl[1];
  assign o_length  = ctrl[3:2];
  assign o_stop2   = ctrl[4];
  assign o_parity  = ctrl[5];
  assign o_odd     = ctrl[6];

endmodule

// File: tb/tb_uart_host_if.sv
// Self-checking bench for uart_host_if: scenario tasks with a read-data scoreboard
// and a negedge monitor that counts and measures the strobes.
module tb_uart_host_if;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_CLKDIV = 2'd3;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [1:0]  i_addr;
  logic        i_we, i_re;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready, o_irq;
  logic [15:0] o_clk_div;
  logic        o_txen, o_rxen;
  logic [1:0]  o_length;
  logic        o_stop2, o_parity, o_odd;
  logic        o_clear_txbuf, o_clear_rxbuf, o_rst_err;
  logic [8:0]  o_data_in;
  logic        o_txwr;
  logic [8:0]  i_data_out = 9'h1FF;
  logic        o_rxrd;
  logic        i_txbuf_empty, i_txbuf_half, i_txbuf_full;
  logic        i_rxbuf_empty, i_rxbuf_half, i_rxbuf_full;
  logic        i_overrun_err, i_parity_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [8:0]  rx_word = 9'h055;

  int txwr_cnt = 0, rxrd_cnt = 0, clrtx_cnt = 0, clrrx_cnt = 0, rsterr_cnt = 0, ready_cnt = 0;
  int run_txwr = 0, run_rxrd = 0, run_clr = 0, max_run = 0;
  logic [8:0] last_data_in = 9'h0;

  uart_host_if #(.CLKDIV_RST(16'd867)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_we(i_we), .i_re(i_re),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ready(o_ready), .o_irq(o_irq),
    .o_clk_div(o_clk_div), .o_txen(o_txen), .o_rxen(o_rxen), .o_length(o_length),
    .o_stop2(o_stop2), .o_parity(o_parity), .o_odd(o_odd),
    .o_clear_txbuf(o_clear_txbuf), .o_clear_rxbuf(o_clear_rxbuf), .o_rst_err(o_rst_err),
    .o_data_in(o_data_in), .o_txwr(o_txwr), .i_data_out(i_data_out), .o_rxrd(o_rxrd),
    .i_txbuf_empty(i_txbuf_empty), .i_txbuf_half(i_txbuf_half), .i_txbuf_full(i_txbuf_full),
    .i_rxbuf_empty(i_rxbuf_empty), .i_rxbuf_half(i_rxbuf_half), .i_rxbuf_full(i_rxbuf_full),
    .i_overrun_err(i_overrun_err), .i_parity_err(i_parity_err)
  );

  always #5 i_clk = ~i_clk;

  // RX core model: popped word is only valid in the cycle after the pop strobe.
  always @(posedge i_clk) i_data_out <= o_rxrd ? rx_word : 9'h1FF;

  always @(negedge i_clk) begin
    if (o_txwr) begin txwr_cnt++; last_data_in = o_data_in; end
    if (o_rxrd) rxrd_cnt++;
    if (o_clear_txbuf) clrtx_cnt++;
    if (o_clear_rxbuf) clrrx_cnt++;
    if (o_rst_err) rsterr_cnt++;
    if (o_ready) ready_cnt++;
    run_txwr = o_txwr ? run_txwr + 1 : 0;
    run_rxrd = o_rxrd ? run_rxrd + 1 : 0;
    run_clr  = (o_clear_txbuf | o_clear_rxbuf | o_rst_err) ? run_clr + 1 : 0;
    if (run_txwr > max_run) max_run = run_txwr;
    if (run_rxrd > max_run) max_run = run_rxrd;
    if (run_clr > max_run) max_run = run_clr;
  end

  task automatic bus(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd);
    @(negedge i_clk);
    i_we = we; i_re = !we; i_addr = addr; i_wdata = wd;
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
    end while (o_ready !== 1'b1 && lat < 20);
    rd = o_rdata;
    i_we = 1'b0; i_re = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd, e;
    i_rst_n = 1'b0; i_we = 0; i_re = 0; i_addr = 0; i_wdata = 0;
    i_txbuf_empty = 1; i_txbuf_half = 0; i_txbuf_full = 0;
    i_rxbuf_empty = 1; i_rxbuf_half = 0; i_rxbuf_full = 0;
    i_overrun_err = 0; i_parity_err = 0;
    #23;
    total++;
    if ({o_ready, o_irq, o_txwr, o_rxrd, o_txen, o_rxen, o_rdata} !== 38'h0) begin
      bad++; $display("[TB] FAIL reset_outputs: got rdy=%b irq=%b txwr=%b rxrd=%b rdata=%h want all 0",
                      o_ready, o_irq, o_txwr, o_rxrd, o_rdata);
    end
    total++;
    if (o_clk_div !== 16'd867) begin bad++; $display("[TB] FAIL reset_clkdiv: got %0d want 867", o_clk_div); end
    @(negedge i_clk); i_rst_n = 1'b1;
    exp_q.push_back(32'd867);
    bus(1'b0, A_CLKDIV, 32'h0, lat, rd);
    e = exp_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("[TB] FAIL reset_clkdiv_read: got %h want %h", rd, e); end
    exp_q.push_back(32'h0);
    bus(1'b0, A_CTRL, 32'h0, lat, rd);
    e = exp_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("[TB] FAIL reset_ctrl_read: got %h want %h", rd, e); end
  endtask

  task automatic test_data_write();
    int lat, t0; logic [31:0] rd;
    t0 = txwr_cnt;
    bus(1'b1, A_DATA, 32'hFFFF_F1A5, lat, rd);
    @(negedge i_clk);
    total++;
    if (lat !== 1) begin bad++; $display("[TB] FAIL wr_latency: got %0d want 1", lat); end
    total++;
    if (txwr_cnt - t0 !== 1) begin bad++; $display("[TB] FAIL wr_txwr_count: got %0d want 1", txwr_cnt - t0); end
    total++;
    if (last_data_in !== 9'h1A5) begin bad++; $display("[TB] FAIL wr_data_in: got %h want 1a5", last_data_in); end
  endtask

  task automatic test_data_read();
    int lat, r0; logic [31:0] rd, e;
    i_rxbuf_empty = 1'b0; rx_word = 9'h055; r0 = rxrd_cnt;
    exp_q.push_back(32'h0000_0055);
    bus(1'b0, A_DATA, 32'h0, lat, rd);
    e = exp_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("[TB] FAIL rd_data: got %h want %h", rd, e); end
    total++;
    if (lat !== 3) begin bad++; $display("[TB] FAIL rd_latency: got %0d want 3", lat); end
    rx_word = 9'h1C3;
    exp_q.push_back(32'h0000_01C3);
    bus(1'b0, A_DATA, 32'h0, lat, rd);
    e = exp_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("[TB] FAIL rd_data2: got %h want %h", rd, e); end
    @(negedge i_clk);
    total++;
    if (rxrd_cnt - r0 !== 2) begin bad++; $display("[TB] FAIL rd_rxrd_count: got %0d want 2", rxrd_cnt - r0); end
    i_rxbuf_empty = 1'b1;
  endtask

  task automatic test_data_read_empty();
    int lat, r0; logic [31:0] rd, e;
    r0 = rxrd_cnt;
    exp_q.push_back(32'h8000_0000);
    bus(1'b0, A_DATA, 32'h0, lat, rd);
    e = exp_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("[TB] FAIL empty_rdata: got %h want %h", rd, e); end
    total++;
    if (lat !== 1) begin bad++; $display("[TB] FAIL empty_latency: got %0d want 1", lat); end
    @(negedge i_clk);
    total++;
    if (rxrd_cnt !== r0) begin bad++; $display("[TB] FAIL empty_rxrd: got %0d pulses want 0", rxrd_cnt - r0); end
  endtask

  task automatic test_tx_drop();
    int lat, t0; logic [31:0] rd, e;
    i_txbuf_empty = 0; i_txbuf_full = 1; i_rxbuf_empty = 0; t0 = txwr_cnt;
    bus(1'b1, A_DATA, 32'h0000_0033, lat, rd);
    @(negedge i_clk);
    total++;
    if (txwr_cnt !== t0) begin bad++; $display("[TB] FAIL drop_txwr: got %0d pulses want 0", txwr_cnt - t0); end
    exp_q.push_back(32'h0000_0104);
    bus(1'b0, A_STATUS, 32'h0, lat, rd);
    e = exp_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("[TB] FAIL drop_status: got %h want %h", rd, e); end
    bus(1'b1, A_STATUS, 32'h0000_0100, lat, rd);
    exp_q.push_back(32'h0000_0004);
    bus(1'b0, A_STATUS, 32'h0, lat, rd);
    e = exp_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("[TB] FAIL drop_clear: got %h want %h", rd, e); end
    i_txbuf_empty = 1; i_txbuf_full = 0; i_rxbuf_empty = 1;
  endtask

  task automatic test_ctrl();
    int lat, ct, cr, ce; logic [31:0] rd, e;
    i_rxbuf_empty = 1'b0;
    ct = clrtx_cnt; cr = clrrx_cnt; ce = rsterr_cnt;
    @(negedge i_clk);
    total++;
    if (o_irq !== 1'b0) begin bad++; $display("[TB] FAIL ctrl_irq_before: got %b want 0", o_irq); end
    bus(1'b1, A_CTRL, 32'h0003_0103, lat, rd);
    @(negedge i_clk);
    total++;
    if ({o_txen, o_rxen} !== 2'b11) begin bad++; $display("[TB] FAIL ctrl_en: got %b%b want 11", o_txen, o_rxen); end
    total++;
    if ({clrtx_cnt - ct, clrrx_cnt - cr, rsterr_cnt - ce} !== {32'd1, 32'd1, 32'd0}) begin
      bad++; $display("[TB] FAIL ctrl_pulses: got tx=%0d rx=%0d err=%0d want 1 1 0",
                      clrtx_cnt - ct, clrrx_cnt - cr, rsterr_cnt - ce);
    end
    total++;
    if (o_irq !== 1'b1) begin bad++; $display("[TB] FAIL ctrl_irq_rx: got %b want 1", o_irq); end
    exp_q.push_back(32'h0000_0103);
    bus(1'b0, A_CTRL, 32'h0, lat, rd);
    e = exp_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("[TB] FAIL ctrl_read: got %h want %h", rd, e); end
    i_rxbuf_empty = 1'b1;
    repeat (2) @(negedge i_clk);
    total++;
    if (o_irq !== 1'b0) begin bad++; $display("[TB] FAIL ctrl_irq_drop: got %b want 0", o_irq); end
    bus(1'b1, A_CTRL, 32'h0000_047C, lat, rd);
    i_parity_err = 1'b1;
    repeat (2) @(negedge i_clk);
    total++;
    if ({o_length, o_stop2, o_parity, o_odd, o_txen, o_rxen, o_irq} !== 8'b1111_1001) begin
      bad++; $display("[TB] FAIL ctrl_line_cfg: got %b want 11111001",
                      {o_length, o_stop2, o_parity, o_odd, o_txen, o_rxen, o_irq});
    end
    i_parity_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, e, v;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      bus(1'b1, A_CLKDIV, v, lat, rd);
      exp_q.push_back({16'h0, v[15:0]});
      bus(1'b0, A_CLKDIV, 32'h0, lat, rd);
      e = exp_q.pop_front(); total++;
      if (rd !== e || o_clk_div !== v[15:0]) begin
        bad++; $display("[TB] FAIL b2b_clkdiv[%0d]: got %h port %h want %h", i, rd, o_clk_div, e);
      end
    end
  endtask

  task automatic test_reset_in_pop();
    int lat, r0, q0; logic [31:0] rd, e;
    i_rxbuf_empty = 1'b0; r0 = rxrd_cnt;
    @(negedge i_clk); i_re = 1; i_we = 0; i_addr = A_DATA;
    @(negedge i_clk); #2;
    total++;
    if (o_rxrd !== 1'b1) begin bad++; $display("[TB] FAIL pop_rxrd: got %b want 1", o_rxrd); end
    i_rst_n = 1'b0; #1;
    total++;
    if ({o_rxrd, o_ready, o_txen, o_irq, o_rdata} !== 36'h0 || o_clk_div !== 16'd867) begin
      bad++; $display("[TB] FAIL pop_reset: got rxrd=%b rdy=%b txen=%b rdata=%h div=%0d want 0s, 867",
                      o_rxrd, o_ready, o_txen, o_rdata, o_clk_div);
    end
    i_re = 0; i_rxbuf_empty = 1'b1;
    @(negedge i_clk); i_rst_n = 1'b1;
    q0 = ready_cnt;
    repeat (3) @(negedge i_clk);
    total++;
    if (rxrd_cnt - r0 !== 1 || ready_cnt !== q0) begin
      bad++; $display("[TB] FAIL pop_abort: got rxrd=%0d ready=%0d want 1 0", rxrd_cnt - r0, ready_cnt - q0);
    end
    exp_q.push_back(32'd867);
    bus(1'b0, A_CLKDIV, 32'h0, lat, rd);
    e = exp_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("[TB] FAIL pop_clkdiv: got %h want %h", rd, e); end
  endtask

  task automatic test_pulse_widths();
    @(negedge i_clk);
    total++;
    if (max_run !== 1) begin bad++; $display("[TB] FAIL strobe_width: got %0d want 1", max_run); end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_data_read();
    test_data_read_empty();
    test_tx_drop();
    test_ctrl();
    test_back_to_back();
    test_reset_in_pop();
    test_pulse_widths();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
